// File: rtl/mips32_pkg.sv
// Shared constants for the mips32 memory arbiter.
// MIPS32_ARB_DBG_PORT_EN adds the third (debug/loader) requester.
package mips32_pkg;

    localparam int REQ_IF   = 0;
    localparam int REQ_DATA = 1;
    localparam int REQ_DBG  = 2;

`ifdef MIPS32_ARB_DBG_PORT_EN
    localparam int NREQ = 3;
`else
    localparam int NREQ = 2;
`endif

    typedef logic [1:0] req_idx_t;

endpackage

// File: rtl/mips32_arb_prio.sv
// Combinational grant picker: starved ports (lowest index first) beat base priority DATA > IF > DBG.
// The DBG leg exists only when MIPS32_ARB_DBG_PORT_EN is defined.
module mips32_arb_prio
    import mips32_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] starved,
    input  logic            mem_busy,
    output logic [NREQ-1:0] gnt,
    output req_idx_t        gnt_idx
);

    logic [NREQ-1:0] cand;

    always_comb begin
        cand    = req & starved;
        gnt     = '0;
        gnt_idx = req_idx_t'(REQ_IF);
        if (!mem_busy && (|req)) begin
            if (|cand) begin
                for (int i = NREQ - 1; i >= 0; i--) begin
                    if (cand[i]) gnt_idx = req_idx_t'(i);
                end
            end else if (req[REQ_DATA]) begin
                gnt_idx = req_idx_t'(REQ_DATA);
            end else if (req[REQ_IF]) begin
                gnt_idx = req_idx_t'(REQ_IF);
`ifdef MIPS32_ARB_DBG_PORT_EN
            end else begin
                gnt_idx = req_idx_t'(REQ_DBG);
`endif
            end
            for (int i = 0; i < NREQ; i++) begin
                gnt[i] = (gnt_idx == req_idx_t'(i));
            end
        end
    end

endmodule

// File: rtl/mips32_mem_arbiter.sv
// Single-port memory arbiter for IF/DATA (and DBG when MIPS32_ARB_DBG_PORT_EN is defined).
// Grant in cycle N, registered memory command in N+1, read return in N+2.
module mips32_mem_arbiter
    import mips32_pkg::*;
#(
    parameter int AW           = 10,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk1,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         we,
    input  logic [NREQ-1:0][AW-1:0] addr,
    input  logic [NREQ-1:0][DW-1:0] wdata,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         rvalid,
    output logic [DW-1:0]           rdata,
    input  logic                    mem_busy,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [AW-1:0]           mem_addr,
    output logic [DW-1:0]           mem_wdata,
    input  logic [DW-1:0]           mem_rdata
);

    localparam int               CNT_W = 4;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] wait_q [NREQ];
    logic [CNT_W-1:0] wait_d [NREQ];
    logic [NREQ-1:0]  starved;
    logic [NREQ-1:0]  we_eff;
    logic             busy_eff;
    logic             gnt_any;
    req_idx_t         gnt_idx;

    logic             mem_en_q, mem_en_d;
    logic             mem_we_q, mem_we_d;
    logic [AW-1:0]    mem_addr_q, mem_addr_d;
    logic [DW-1:0]    mem_wdata_q, mem_wdata_d;

    logic             rd_vld_p0_q, rd_vld_p0_d;
    req_idx_t         rd_idx_p0_q, rd_idx_p0_d;
    logic             rd_vld_p1_q;
    req_idx_t         rd_idx_p1_q;

    // Reset masks grants so nothing is issued while it is held.
    assign busy_eff = mem_busy | rst;

    mips32_arb_prio u_prio (
        .req     (req),
        .starved (starved),
        .mem_busy(busy_eff),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign gnt_any = |gnt;

    always_comb begin
        we_eff         = we;
        we_eff[REQ_IF] = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            starved[i] = (wait_q[i] == LIMIT);
            if (!req[i] || gnt[i]) begin
                wait_d[i] = '0;
            end else if (!mem_busy && !starved[i]) begin
                wait_d[i] = wait_q[i] + 1'b1;
            end else begin
                wait_d[i] = wait_q[i];
            end
        end
    end

    // One-hot mux keeps the address of non-requesting ports out of the command path.
    always_comb begin
        mem_en_d    = gnt_any;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                mem_we_d    = we_eff[i];
                mem_addr_d  = addr[i];
                mem_wdata_d = wdata[i];
            end
        end
        rd_vld_p0_d = gnt_any & ~mem_we_d;
        rd_idx_p0_d = gnt_idx;
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) wait_q[i] <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_vld_p0_q <= 1'b0;
            rd_idx_p0_q <= '0;
            rd_vld_p1_q <= 1'b0;
            rd_idx_p1_q <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) wait_q[i] <= wait_d[i];
            // Command stage (aligned with mem_en)
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rd_vld_p0_q <= rd_vld_p0_d;
            rd_idx_p0_q <= rd_idx_p0_d;
            // Return stage (aligned with mem_rdata)
            rd_vld_p1_q <= rd_vld_p0_q;
            rd_idx_p1_q <= rd_idx_p0_q;
        end
    end

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            rvalid[i] = rd_vld_p1_q && (rd_idx_p1_q == req_idx_t'(i));
        end
    end

    assign rdata     = mem_rdata;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
